// File: rtl/branch_pkg.sv
// Shared types for the branch predictor and the branch resolution unit.
// Holds the prediction entry layout, control-flow opcodes and resolver states.
package branch_pkg;

    // Stored PC/target width of a prediction entry.
    localparam int PRED_XLEN = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [PRED_XLEN-1:0] pc;
        logic                 taken;
        logic [PRED_XLEN-1:0] target;
    } pred_entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } bru_state_e;

    function automatic logic is_ctrl_flow(input logic [6:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_JAL);
    endfunction

endpackage

// File: rtl/branch_resolution_unit_pred_queue.sv
// In-order FIFO of fetch-time predictions awaiting resolution in execute.
// Ports: push/push_data in, pop, clear (flush all), head/full/empty out.
module pred_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  pred_entry_t push_data,
    input  logic        pop,
    input  logic        clear,
    output pred_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry an extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    pred_entry_t mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW])
                  && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// Checks fetch-time predictions against execute outcomes, trains the predictor,
// redirects/squashes the front end and counts branches and mispredictions.
// Ports: push_*_f from fetch, resolve_*/actual_* from execute,
// mispredict + update bundle + redirect (registered, one-cycle), counters,
// sticky order_error. Entries store PC/target at PRED_XLEN width.
module branch_resolution_unit
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid_f,
    input  logic [DATA_WIDTH-1:0] push_pc_f,
    input  logic                  push_taken_f,
    input  logic [DATA_WIDTH-1:0] push_target_f,
    output logic                  push_ready_f,
    input  logic                  resolve_valid_e,
    input  logic [DATA_WIDTH-1:0] resolve_pc_e,
    input  logic                  resolve_jal_e,
    input  logic                  actual_taken_e,
    input  logic [DATA_WIDTH-1:0] actual_target_e,
    output logic                  mispredict,
    output logic                  branch_actual_taken,
    output logic [DATA_WIDTH-1:0] branch_actual_target,
    output logic                  type_j,
    output logic [DATA_WIDTH-1:0] branch_pc,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count,
    output logic                  order_error
);

    bru_state_e  state_q;
    pred_entry_t push_entry;
    pred_entry_t head;
    logic        q_full;
    logic        q_empty;
    logic        q_push;
    logic        q_pop;

    logic                  entry_ok;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;
    logic                  mp_now;
    logic [DATA_WIDTH-1:0] next_pc;

    assign push_entry.pc     = PRED_XLEN'(push_pc_f);
    assign push_entry.taken  = push_taken_f;
    assign push_entry.target = PRED_XLEN'(push_target_f);

    // A missing or out-of-order head is treated as predicted not-taken to 0.
    assign entry_ok    = !q_empty
                      && (DATA_WIDTH'(head.pc) == resolve_pc_e);
    assign pred_taken  = entry_ok && head.taken;
    assign pred_target = entry_ok ? DATA_WIDTH'(head.target) : '0;

    assign mp_now = resolve_valid_e
                 && ((pred_taken != actual_taken_e)
                  || (actual_taken_e && (pred_target != actual_target_e)));

    assign next_pc = actual_taken_e ? actual_target_e
                                    : resolve_pc_e + DATA_WIDTH'(4);

    assign push_ready_f = !q_full;

    // Pushes racing a mispredict or landing in SQUASH are wrong-path.
    assign q_push = push_valid_f && !q_full
                 && (state_q == RUN) && !mp_now;
    assign q_pop  = resolve_valid_e;

    pred_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .clear     (mp_now),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q              <= RUN;
            mispredict           <= 1'b0;
            redirect_valid       <= 1'b0;
            branch_actual_taken  <= 1'b0;
            branch_actual_target <= '0;
            type_j               <= 1'b0;
            branch_pc            <= '0;
            redirect_pc          <= '0;
            branch_count         <= '0;
            mispredict_count     <= '0;
            order_error          <= 1'b0;
        end else begin
            mispredict           <= mp_now;
            redirect_valid       <= mp_now;
            branch_actual_taken  <= mp_now && actual_taken_e;
            branch_actual_target <= mp_now ? actual_target_e : '0;
            type_j               <= mp_now && resolve_jal_e;
            branch_pc            <= mp_now ? resolve_pc_e : '0;
            redirect_pc          <= mp_now ? next_pc : '0;

            if (resolve_valid_e && (branch_count != '1))
                branch_count <= branch_count + 1'b1;
            if (mp_now && (mispredict_count != '1))
                mispredict_count <= mispredict_count + 1'b1;
            if (resolve_valid_e && !entry_ok)
                order_error <= 1'b1;

            unique case (state_q)
                RUN:     if (mp_now) state_q <= SQUASH;
                SQUASH:  state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

endmodule
